quad_encoder_rpm: RTL

Parametrised quadrature-encoder front end: synchronises the A/B encoder pins, decodes them at x4 resolution with direction, keeps a signed absolute position, and produces a signed speed (RPM) value once per fixed sampling window. It replaces the single-channel, count-up-only tick counter as the speed-feedback source for motor-control loops. Everything is in one clock domain; the encoder pins are the only asynchronous inputs.

---
 rtl/quad_encoder_rpm.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/quad_encoder_rpm.sv
// ---------------------------------------------------------------------------
// quad_encoder_rpm
//
// Quadrature-encoder front end. It synchronises the A/B pins and decodes them
// at x4 resolution with direction. It keeps a signed absolute position and
// reports a signed speed once per fixed window of WINDOW_CYCLES clocks.
//
// Speed conversion: rpm = sign(n) * ((|n| * RPM_MUL) >> RPM_SHIFT), where n is
// the saturated edge count of the window. The result is saturated to RPM_W
// bits.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous, active-high reset
//   enc_a      encoder channel A (asynchronous)
//   enc_b      encoder channel B (asynchronous)
//   clear_pos  synchronous position clear; wins over a same-cycle step
//   pos        signed absolute position in x4 counts (wraps)
//   dir        direction of the last valid edge, 1 = forward
//   rpm        signed speed of the last completed window
//   rpm_valid  one-cycle pulse in the cycle rpm updates
//   err        sticky illegal-transition flag, cleared only by rst
// ---------------------------------------------------------------------------
module quad_encoder_rpm #(
    parameter int WINDOW_CYCLES = 160000,
    parameter int CNT_W         = 16,
    parameter int POS_W         = 32,
    parameter int RPM_W         = 16,
    parameter int RPM_MUL       = 60,
    parameter int RPM_SHIFT     = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear_pos,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic [RPM_W-1:0] rpm,
    output logic             rpm_valid,
    output logic             err
);

    localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    // Wide enough for |count| (CNT_W+1 bits) times a 32-bit multiplier.
    localparam int MW   = CNT_W + 1 + 32;

    // Saturate a one-bit-wider sum back into CNT_W bits. Steps are +-1, so
    // overflow shows up as the top two bits disagreeing.
    function automatic logic signed [CNT_W-1:0] sat_cnt(input logic signed [CNT_W:0] s);
        logic signed [CNT_W-1:0] r;
        if (s[CNT_W] != s[CNT_W-1])
            r = s[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
        else
            r = s[CNT_W-1:0];
        return r;
    endfunction

    // Window count to rpm: scale the magnitude, reapply the sign (so the
    // rounding is toward zero), then saturate to the signed RPM_W range.
    function automatic logic signed [RPM_W-1:0] to_rpm(input logic signed [CNT_W-1:0] c);
        logic [CNT_W:0]   ax;
        logic [MW-1:0]    mag;
        logic [MW-1:0]    pmax;
        logic [MW-1:0]    nmax;
        logic [RPM_W-1:0] r;
        ax   = c[CNT_W-1] ? (~{c[CNT_W-1], c} + 1'b1) : {1'b0, c};
        mag  = (MW'(ax) * MW'(RPM_MUL)) >> RPM_SHIFT;
        pmax = MW'({(RPM_W-1){1'b1}});
        nmax = pmax + MW'(1);
        if (!c[CNT_W-1])
            r = (mag > pmax) ? pmax[RPM_W-1:0] : mag[RPM_W-1:0];
        else
            r = (mag > nmax) ? {1'b1, {(RPM_W-1){1'b0}}} : (~mag[RPM_W-1:0] + 1'b1);
        return $signed(r);
    endfunction

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [SYNC_STAGES-1:0] fill;
    logic [1:0]             cur_ab;
    logic [1:0]             prev_ab;
    logic                   primed;
    logic signed [1:0]      step;
    logic                   illegal;

    logic signed [POS_W-1:0] pos_q;
    logic                    dir_q;
    logic                    err_q;

    logic [WC_W-1:0]         wcnt;
    logic                    terminal;
    logic signed [CNT_W-1:0] ecnt;
    logic signed [CNT_W-1:0] win_total_p0;
    logic signed [RPM_W-1:0] rpm_p1;
    logic                    vld_p1;

    // ---- stage: pin synchronisers --------------------------------------
    // fill marks how far the first post-reset sample has travelled, so that
    // prev_ab is primed with a real pin value rather than a reset zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            fill   <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
            fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign cur_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // ---- stage: x4 decode ------------------------------------------------
    // Gray order 00 -> 01 -> 11 -> 10 -> 00 is forward.
    always_comb begin
        step    = 2'sb00;
        illegal = 1'b0;
        if (primed) begin
            case ({prev_ab, cur_ab})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: step = 2'sb01;
                4'b0100, 4'b1101, 4'b1011, 4'b0010: step = 2'sb11;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
                default: step = 2'sb00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ab <= 2'b00;
            primed  <= 1'b0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (primed || fill[SYNC_STAGES-1]) begin
                prev_ab <= cur_ab;
                primed  <= 1'b1;
            end
            if (clear_pos)
                pos_q <= '0;
            else
                pos_q <= pos_q + {{(POS_W-2){step[1]}}, step};
            if (step != 2'sb00)
                dir_q <= ~step[1];
            if (illegal)
                err_q <= 1'b1;
        end
    end

    // ---- stage: window and edge counting ---------------------------------
    assign terminal     = (wcnt == WC_W'(WINDOW_CYCLES - 1));
    // Includes this cycle's step, so a step in the terminal cycle lands in
    // the window that is closing.
    assign win_total_p0 = sat_cnt({ecnt[CNT_W-1], ecnt} + {{(CNT_W-1){step[1]}}, step});

    // ---- stage: speed conversion and output register ---------------------
    // The closing window total is converted and registered at the terminal
    // edge, so rpm and rpm_valid appear together in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt   <= '0;
            ecnt   <= '0;
            rpm_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= terminal;
            if (terminal) begin
                wcnt   <= '0;
                ecnt   <= '0;
                rpm_p1 <= to_rpm(win_total_p0);
            end else begin
                wcnt   <= wcnt + WC_W'(1);
                ecnt   <= win_total_p0;
            end
        end
    end

    assign pos       = pos_q;
    assign dir       = dir_q;
    assign err       = err_q;
    assign rpm       = rpm_p1;
    assign rpm_valid = vld_p1;

endmodule
